// File: rtl/lcd_rx_pkg.sv
// Shared types and constants for the HD44780 4-bit bus responder.
package lcd_rx_pkg;

  typedef enum logic [1:0] {
    S_8BIT = 2'd0,
    S_4HI  = 2'd1,
    S_4LO  = 2'd2
  } state_t;

  localparam int E_BIT  = 2;
  localparam int RS_BIT = 1;
  localparam int RW_BIT = 0;

  localparam int BUSY_W = 17;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_SETDD = 8'h80;
  localparam logic [3:0] FSET_4BIT = 4'h2;
  localparam logic [3:0] FSET_8BIT = 4'h3;

  // Clear and both home encodings (0x02/0x03) get the long busy window.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return (!rs) && ((b == CMD_CLEAR) || ((b & 8'hFE) == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_rx_sync.sv
// Two-flop synchronizer for the seven LCD pins plus the E falling-edge pulse.
module lcd_rx_sync
  import lcd_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dat,
  input  logic [2:0] ctl,
  output logic [3:0] dat_sync,
  output logic [2:0] ctl_sync,
  output logic       e_fall
);

  logic [6:0] meta_r;
  logic [6:0] sync_r;
  logic       e_dly_r;

  // synchronizer chain plus one extra E stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r  <= 7'd0;
      sync_r  <= 7'd0;
      e_dly_r <= 1'b0;
    end else begin
      meta_r  <= {ctl, dat};
      sync_r  <= meta_r;
      e_dly_r <= sync_r[4 + E_BIT];
    end
  end

  assign dat_sync = sync_r[3:0];
  assign ctl_sync = sync_r[6:4];
  assign e_fall   = e_dly_r & ~sync_r[4 + E_BIT];

endmodule

// File: rtl/lcd_hd44780_rx.sv
// HD44780-style 4-bit bus responder: byte rebuild, mode tracking, cursor model
// and busy / E-width / read-strobe error flags.
module lcd_hd44780_rx
  import lcd_rx_pkg::*;
#(
  parameter int EXEC_CYC  = 2000,
  parameter int CLEAR_CYC = 82000,
  parameter int EMIN_CYC  = 12
) (
  input  logic       clk_in,
  input  logic       nClear,
  input  logic [3:0] lcd_dataout,
  input  logic [2:0] lcd_control,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_rs,
  output logic       four_bit_mode,
  output logic [6:0] ddram_addr,
  output logic       err_busy,
  output logic       err_pulse,
  output logic       err_read
);

  localparam int EW_W = $clog2(EMIN_CYC + 1);
  localparam logic [EW_W-1:0]   EMIN_V  = EW_W'(EMIN_CYC);
  localparam logic [BUSY_W-1:0] EXEC_V  = BUSY_W'(EXEC_CYC);
  localparam logic [BUSY_W-1:0] CLEAR_V = BUSY_W'(CLEAR_CYC);

  logic [3:0] dat_s;
  logic [2:0] ctl_s;
  logic       e_fall_s;

  logic [EW_W-1:0]   ewidth_r;
  logic              stb_r;
  logic [3:0]        nib_r;
  logic              rs_r;
  logic              rw_r;
  logic              short_r;
  logic [3:0]        hi_r;
  logic              hi_rs_r;
  logic [BUSY_W-1:0] busy_r;
  state_t            state_r;

  state_t     state_nx_s;
  logic       emit_s;
  logic [7:0] emit_byte_s;
  logic       emit_rs_s;
  logic       fbm_nx_s;
  logic       hi_load_s;

  lcd_rx_sync u_sync (
    .clk      (clk_in),
    .rst_n    (nClear),
    .dat      (lcd_dataout),
    .ctl      (lcd_control),
    .dat_sync (dat_s),
    .ctl_sync (ctl_s),
    .e_fall   (e_fall_s)
  );

  // E-high width counter and capture of the nibble at the E falling edge
  always_ff @(posedge clk_in or negedge nClear) begin
    if (!nClear) begin
      ewidth_r <= '0;
      stb_r    <= 1'b0;
      nib_r    <= 4'h0;
      rs_r     <= 1'b0;
      rw_r     <= 1'b0;
      short_r  <= 1'b0;
    end else begin
      stb_r <= e_fall_s;
      if (e_fall_s) begin
        nib_r   <= dat_s;
        rs_r    <= ctl_s[RS_BIT];
        rw_r    <= ctl_s[RW_BIT];
        short_r <= (ewidth_r < EMIN_V);
      end
      if (ctl_s[E_BIT]) begin
        if (ewidth_r < EMIN_V) begin
          ewidth_r <= ewidth_r + EW_W'(1);
        end
      end else begin
        ewidth_r <= '0;
      end
    end
  end

  // mode FSM next state and byte emission
  always_comb begin
    state_nx_s  = state_r;
    emit_s      = 1'b0;
    emit_byte_s = 8'h00;
    emit_rs_s   = 1'b0;
    fbm_nx_s    = four_bit_mode;
    hi_load_s   = 1'b0;
    if (stb_r && !rw_r) begin
      case (state_r)
        S_8BIT: begin
          emit_s      = 1'b1;
          emit_byte_s = {nib_r, 4'h0};
          emit_rs_s   = rs_r;
          if (!rs_r && (nib_r == FSET_4BIT)) begin
            state_nx_s = S_4HI;
            fbm_nx_s   = 1'b1;
          end else begin
            state_nx_s = S_8BIT;
          end
        end
        S_4HI: begin
          hi_load_s  = 1'b1;
          state_nx_s = S_4LO;
        end
        S_4LO: begin
          emit_s      = 1'b1;
          emit_byte_s = {hi_r, nib_r};
          emit_rs_s   = hi_rs_r;
          if (!hi_rs_r && (hi_r == FSET_8BIT)) begin
            state_nx_s = S_8BIT;
            fbm_nx_s   = 1'b0;
          end else begin
            state_nx_s = S_4HI;
          end
        end
        default: begin
          state_nx_s = S_8BIT;
          fbm_nx_s   = 1'b0;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk_in or negedge nClear) begin
    if (!nClear) begin
      state_r <= S_8BIT;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // registered outputs, busy window, stored high nibble and cursor model
  always_ff @(posedge clk_in or negedge nClear) begin
    if (!nClear) begin
      rx_valid      <= 1'b0;
      rx_byte       <= 8'h00;
      rx_rs         <= 1'b0;
      four_bit_mode <= 1'b0;
      ddram_addr    <= 7'h00;
      err_busy      <= 1'b0;
      err_pulse     <= 1'b0;
      err_read      <= 1'b0;
      busy_r        <= '0;
      hi_r          <= 4'h0;
      hi_rs_r       <= 1'b0;
    end else begin
      rx_valid      <= emit_s;
      four_bit_mode <= fbm_nx_s;
      err_read      <= stb_r & rw_r;
      err_pulse     <= stb_r & ~rw_r & short_r;
      err_busy      <= stb_r & ~rw_r & (state_r != S_4LO) & (busy_r != '0);
      if (hi_load_s) begin
        hi_r    <= nib_r;
        hi_rs_r <= rs_r;
      end
      if (emit_s) begin
        rx_byte <= emit_byte_s;
        rx_rs   <= emit_rs_s;
        busy_r  <= is_long_cmd(emit_rs_s, emit_byte_s) ? CLEAR_V : EXEC_V;
        if (emit_rs_s) begin
          ddram_addr <= ddram_addr + 7'd1;
        end else if ((emit_byte_s & CMD_SETDD) != 8'h00) begin
          ddram_addr <= emit_byte_s[6:0];
        end else if (is_long_cmd(emit_rs_s, emit_byte_s)) begin
          ddram_addr <= 7'h00;
        end
      end else if (busy_r != '0) begin
        busy_r <= busy_r - BUSY_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Scoreboard bench for lcd_hd44780_rx: stimulus pushes expected output events,
// a monitor pops and compares whenever any output strobe fires.
module tb_lcd_hd44780_rx;

  typedef struct packed {
    logic       v;
    logic [7:0] b;
    logic       rs;
    logic [6:0] a;
    logic       fbm;
    logic       eb;
    logic       ep;
    logic       er;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] dat;
  logic [2:0] ctl;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_rs;
  logic       four_bit_mode;
  logic [6:0] ddram_addr;
  logic       err_busy;
  logic       err_pulse;
  logic       err_read;

  int   n_checks = 0;
  int   n_pass   = 0;
  ev_t  exp_q[$];
  ev_t  act_ev;
  ev_t  exp_ev;

  lcd_hd44780_rx #(
    .EXEC_CYC  (20),
    .CLEAR_CYC (100),
    .EMIN_CYC  (4)
  ) dut (
    .clk_in        (clk),
    .nClear        (rst_n),
    .lcd_dataout   (dat),
    .lcd_control   (ctl),
    .rx_valid      (rx_valid),
    .rx_byte       (rx_byte),
    .rx_rs         (rx_rs),
    .four_bit_mode (four_bit_mode),
    .ddram_addr    (ddram_addr),
    .err_busy      (err_busy),
    .err_pulse     (err_pulse),
    .err_read      (err_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic v, input logic [7:0] b, input logic rs, input logic [6:0] a,
                      input logic fbm, input logic eb, input logic ep, input logic er);
    ev_t e;
    e = '{v: v, b: b, rs: rs, a: a, fbm: fbm, eb: eb, ep: ep, er: er};
    exp_q.push_back(e);
  endtask

  task automatic send_nib(input logic [3:0] n, input logic rs, input logic rw,
                          input int eh, input int gap);
    @(negedge clk);
    dat = n;
    ctl = {1'b0, rs, rw};
    repeat (2) @(negedge clk);
    ctl[2] = 1'b1;
    repeat (eh) @(negedge clk);
    ctl[2] = 1'b0;
    repeat (3) @(negedge clk);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rs, input int lo_eh, input int gap);
    send_nib(b[7:4], rs, 1'b0, 6, 10);
    send_nib(b[3:0], rs, 1'b0, lo_eh, gap);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_byte"}, {24'd0, rx_byte}, 32'h00);
    chk({tag, "_rs"},   {31'd0, rx_rs}, 32'h0);
    chk({tag, "_addr"}, {25'd0, ddram_addr}, 32'h00);
    chk({tag, "_fbm"},  {31'd0, four_bit_mode}, 32'h0);
    chk({tag, "_strb"}, {28'd0, rx_valid, err_busy, err_pulse, err_read}, 32'h0);
  endtask

  // monitor: every output strobe must match the next expected event
  always @(negedge clk) begin
    if (rst_n && (rx_valid || err_busy || err_pulse || err_read)) begin
      act_ev = {rx_valid, rx_byte, rx_rs, ddram_addr, four_bit_mode, err_busy, err_pulse, err_read};
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got %h expected none", act_ev);
      end else begin
        exp_ev = exp_q.pop_front();
        chk("event", {11'd0, act_ev}, {11'd0, exp_ev});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    dat   = 4'h0;
    ctl   = 3'b000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("reset");

    // power-up init in 8-bit mode, last nibble switches to 4-bit
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 8'h30, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      send_nib(4'h3, 1'b0, 1'b0, 6, 120);
    end
    push(1'b1, 8'h20, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    send_nib(4'h2, 1'b0, 1'b0, 6, 120);

    // set address 0 then two data writes
    push(1'b1, 8'h80, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h80, 1'b0, 6, 120);
    push(1'b1, 8'h48, 1'b1, 7'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h48, 1'b1, 6, 120);
    push(1'b1, 8'h69, 1'b1, 7'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h69, 1'b1, 6, 120);

    // address wrap, clear, busy-window violation and clean retry
    push(1'b1, 8'hFF, 1'b0, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 6, 120);
    push(1'b1, 8'h41, 1'b1, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h41, 1'b1, 6, 120);
    push(1'b1, 8'h01, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 6, 50);
    push(1'b0, 8'h01, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    push(1'b1, 8'h42, 1'b1, 7'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h42, 1'b1, 6, 120);
    push(1'b1, 8'h01, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 6, 110);
    push(1'b1, 8'h42, 1'b1, 7'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h42, 1'b1, 6, 120);

    // short E pulse on the low nibble, then a read strobe
    push(1'b1, 8'h43, 1'b1, 7'h02, 1'b1, 1'b0, 1'b1, 1'b0);
    send_byte(8'h43, 1'b1, 2, 120);
    push(1'b0, 8'h43, 1'b1, 7'h02, 1'b1, 1'b0, 1'b0, 1'b1);
    send_nib(4'h7, 1'b0, 1'b1, 6, 120);
    push(1'b1, 8'h44, 1'b1, 7'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h44, 1'b1, 6, 120);

    // reset with a half-received byte pending
    send_nib(4'h4, 1'b1, 1'b0, 6, 10);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("midrst");
    push(1'b1, 8'h50, 1'b1, 7'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    send_nib(4'h5, 1'b1, 1'b0, 6, 120);

    // into 4-bit mode and back to 8-bit via function set DL=1
    push(1'b1, 8'h20, 1'b0, 7'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    send_nib(4'h2, 1'b0, 1'b0, 6, 120);
    push(1'b1, 8'h30, 1'b0, 7'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h30, 1'b0, 6, 120);
    push(1'b1, 8'h50, 1'b0, 7'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    send_nib(4'h5, 1'b0, 1'b0, 6, 120);

    for (int i = 0; i < 500 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    chk("drain", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
